// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared sizes and state encoding for the round-robin mux arbiter
package mux8_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
endpackage

// File: rtl/mux8.sv
// mux8: gate-level 8:1 single-bit mux built from decoded and-or terms
module mux8 (
  input  logic [7:0] i,
  input  logic [2:0] sel,
  output logic       y
);
  logic [7:0] term;
  for (genvar g = 0; g < 8; g++) begin : g_term
    assign term[g] = i[g] & (sel == 3'(g));
  end
  assign y = |term;
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick, first set req bit scanning from ptr upward with wrap
import mux8_arb_pkg::*;
module rr_pick8 (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot,
  output logic             any
);
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  assign rot = N_REQ'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) if (rot[k]) off = SEL_W'(k);
  end
  assign any    = |req;
  assign idx    = off + ptr;
  assign onehot = any ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter sharing one 8:1 mux; registered grant, select, data and valid.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD consecutive grant cycles.
import mux8_arb_pkg::*;
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] i,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             valid,
  output logic             busy
);
  if (MAX_HOLD < 1 || MAX_HOLD > 8 || (2 ** HOLD_W) < MAX_HOLD) begin : g_bad_cfg
    $error("mux8_rr_arbiter: illegal MAX_HOLD/HOLD_W");
  end
  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, pick_oh;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, pick_ptr, pick_idx;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             y_q, y_d, valid_q, valid_d, pick_any, mux_y, timeout, rel;
`ifdef ARB_TIMEOUT_EN
  assign timeout = hold_q == HOLD_W'(MAX_HOLD - 1);
`else
  assign timeout = 1'b0;
`endif
  assign rel      = state_q == ARB_GRANT && (!req[sel_q] || timeout);
  // On release the search starts just past the outgoing owner, so it is re-arbitrated in the same edge.
  assign pick_ptr = state_q == ARB_GRANT ? sel_q + 3'd1 : ptr_q;
  rr_pick8 u_pick (.req(req), .ptr(pick_ptr), .idx(pick_idx), .onehot(pick_oh), .any(pick_any));
  mux8 u_mux (.i(i), .sel(sel_q), .y(mux_y));
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    y_d     = y_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (state_q == ARB_IDLE) begin
      gnt_d   = '0;
      valid_d = 1'b0;
      if (pick_any) begin
        state_d = ARB_GRANT;
        gnt_d   = pick_oh;
        sel_d   = pick_idx;
        hold_d  = '0;
      end
    end else begin
      y_d     = mux_y;
      valid_d = 1'b1;
      hold_d  = &hold_q ? hold_q : hold_q + 1'b1;
      if (rel) begin
        ptr_d = sel_q + 3'd1;
        if (pick_any) begin
          gnt_d  = pick_oh;
          sel_d  = pick_idx;
          hold_d = '0;
        end else begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          valid_d = 1'b0;
          y_d     = y_q;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end
  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign y     = y_q;
  assign valid = valid_q;
  assign busy  = state_q == ARB_GRANT;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: vector table plus hand sequences, expectations queued at drive time and checked after each edge
module tb_mux8_rr_arbiter;
  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       valid;
    logic       busy;
  } exp_t;
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] i;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [7:0] req = '0, i = '0, gnt;
  logic [2:0] sel;
  logic       y, valid, busy;
  int         total = 0, bad = 0;
  exp_t       sb[$];
  vec_t       v[21];

`ifdef ARB_TIMEOUT_EN
  mux8_rr_arbiter #(.MAX_HOLD(2), .HOLD_W(3)) dut (
`else
  mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut (
`endif
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(gnt), .sel(sel), .y(y), .valid(valid), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] iv, input exp_t e, input string nm);
    exp_t x;
    rst = r;
    req = rq;
    i   = iv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(nm, 16'({gnt, sel, y, valid, busy}), 16'(x));
  endtask

  initial begin
    // rst, req, i, {gnt, sel, y, valid, busy}
    v[0]  = '{1'b1, 8'h00, 8'h00, '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0}};
    v[1]  = '{1'b0, 8'h20, 8'h20, '{8'h20, 3'd5, 1'b0, 1'b0, 1'b1}};
    v[2]  = '{1'b0, 8'h20, 8'h20, '{8'h20, 3'd5, 1'b1, 1'b1, 1'b1}};
    v[3]  = '{1'b0, 8'h00, 8'h20, '{8'h00, 3'd5, 1'b1, 1'b0, 1'b0}};
    v[4]  = '{1'b0, 8'h00, 8'h00, '{8'h00, 3'd5, 1'b1, 1'b0, 1'b0}};
    v[5]  = '{1'b0, 8'h80, 8'h00, '{8'h80, 3'd7, 1'b1, 1'b0, 1'b1}};
    v[6]  = '{1'b0, 8'h81, 8'h80, '{8'h80, 3'd7, 1'b1, 1'b1, 1'b1}};
    v[7]  = '{1'b0, 8'h01, 8'h00, '{8'h01, 3'd0, 1'b0, 1'b1, 1'b1}};
    v[8]  = '{1'b0, 8'h80, 8'h01, '{8'h80, 3'd7, 1'b1, 1'b1, 1'b1}};
    v[9]  = '{1'b0, 8'h00, 8'h00, '{8'h00, 3'd7, 1'b1, 1'b0, 1'b0}};
    v[10] = '{1'b0, 8'h0C, 8'h08, '{8'h04, 3'd2, 1'b1, 1'b0, 1'b1}};
    v[11] = '{1'b0, 8'h0C, 8'h04, '{8'h04, 3'd2, 1'b1, 1'b1, 1'b1}};
    v[12] = '{1'b0, 8'h08, 8'h00, '{8'h08, 3'd3, 1'b0, 1'b1, 1'b1}};
    v[13] = '{1'b0, 8'h08, 8'h08, '{8'h08, 3'd3, 1'b1, 1'b1, 1'b1}};
    v[14] = '{1'b0, 8'h0F, 8'hF7, '{8'h08, 3'd3, 1'b0, 1'b1, 1'b1}};
    v[15] = '{1'b0, 8'h09, 8'h08, '{8'h08, 3'd3, 1'b1, 1'b1, 1'b1}};
    v[16] = '{1'b0, 8'h08, 8'hF7, '{8'h08, 3'd3, 1'b0, 1'b1, 1'b1}};
    v[17] = '{1'b0, 8'h01, 8'h00, '{8'h01, 3'd0, 1'b0, 1'b1, 1'b1}};
    v[18] = '{1'b1, 8'h01, 8'hFF, '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0}};
    v[19] = '{1'b0, 8'h41, 8'h00, '{8'h01, 3'd0, 1'b0, 1'b0, 1'b1}};
    v[20] = '{1'b0, 8'h00, 8'h00, '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0}};
    @(posedge clk);
    #1;
`ifndef ARB_TIMEOUT_EN
    for (int k = 0; k < 21; k++) step(v[k].rst, v[k].req, v[k].i, v[k].e, $sformatf("vec%0d", k));
    // requester 3 keeps the grant for 20 cycles while requester 0 waits
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 8'h09, 8'h00, '{8'h08, 3'd3, 1'b0, (k != 0), 1'b1}, $sformatf("hold%0d", k));
    end
    step(1'b0, 8'h01, 8'h00, '{8'h01, 3'd0, 1'b0, 1'b1, 1'b1}, "handoff");
`else
    step(1'b1, 8'h00, 8'h00, '{8'h00, 3'd0, 1'b0, 1'b0, 1'b0}, "rot_reset");
    for (int k = 0; k < 18; k++) begin
      rst = 1'b0;
      req = 8'hFF;
      @(posedge clk);
      #1;
      chk($sformatf("rot%0d", k), 16'(gnt), 16'(8'h01 << ((k / 2) % 8)));
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer that shares one 8:1 single-bit mux between 8 requesters.
- Each requester raises req[k]. The block grants one requester at a time, drives the mux select, and returns the selected data bit registered with a valid flag.
- Sits between the requester logic and the 8:1 mux datapath. It is the only driver of that mux's select lines.

Parameters:
- MAX_HOLD, 4, maximum consecutive grant cycles per requester (used only when ARB_TIMEOUT_EN is defined); legal range 1..8.
- HOLD_W, 3, width of the hold counter; must satisfy 2**HOLD_W >= MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  8  request vector; req[k] is level-held by requester k.
- i  input  8  data bits; i[k] belongs to requester k.
- gnt  output  8  one-hot grant (registered); all zero when no grant.
- sel  output  3  mux select; equals the index of gnt when gnt != 0.
- y  output  1  registered data bit i[sel].
- valid  output  1  high when y holds data from a granted requester.
- busy  output  1  high while state == GRANT.

Behaviour:
- States are IDLE and GRANT.
- Reset (rst=1 at an edge), which overrides everything, including mid-grant:
  - state=IDLE; gnt=0, sel=0, y=0, valid=0, busy=0; ptr=0, hold_cnt=0.
- Pick function: the first index k with req[k]=1, scanning ptr, ptr+1, ..., wrapping modulo 8.
- IDLE:
  - If req != 0 at the edge: gnt <= onehot(pick), sel <= pick, hold_cnt <= 0, go to GRANT.
  - Otherwise remain in IDLE, gnt=0, and sel holds its last value.
- Latency: req rising before edge N gives gnt visible after edge N. The first valid y is visible after edge N+1.
- GRANT, every edge: y <= i[sel], valid <= 1, hold_cnt <= hold_cnt+1.
- Release occurs when req[sel]=0 at the edge, or on timeout (see Optional Feature). On release:
  - ptr <= sel+1 (3-bit wrap, 7 -> 0).
  - Re-arbitrate in the same edge using the new ptr and the current req. Back-to-back grants have no idle cycle.
  - If no request remains: state <= IDLE, gnt <= 0, valid <= 0 on that edge. y keeps its last value.
- A requester that is re-granted alone after timeout gets a fresh hold_cnt of 0.
- Simultaneous requests: the lowest index at or after ptr wins.
- req changes on non-granted lines have no effect during GRANT.
- Invariants:
  - gnt is always one-hot or zero.
  - sel never changes while state stays in GRANT with the same owner.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined: release is forced when hold_cnt == MAX_HOLD-1 and req[sel] is still 1. That is, at most MAX_HOLD consecutive grant cycles, then round-robin moves on.
- Undefined: a grant is held until req[sel] drops. hold_cnt is still maintained (saturating at all ones) but never forces release.

Decomposition:
- Package mux8_arb_pkg:
  - N_REQ=8, SEL_W=3.
  - State enum arb_state_t {ARB_IDLE, ARB_GRANT}.
- Sub-module rr_pick8, purely combinational:
  - Inputs req[7:0] and ptr[2:0].
  - Outputs idx[2:0], onehot[7:0] and any.
- The datapath is the existing gate-level 8:1 mux, instantiated with i and sel. Its output is registered into y.

Test Plan:
- Reset mid-grant: req=8'h04, grant on requester 2; assert rst one cycle -> next edge gnt=0, valid=0, busy=0, sel=0, ptr=0.
- Single requester: req=8'h20, i=8'h20 -> gnt=8'h20 after 1 edge, sel=5, y=1 with valid=1 after 2 edges; drop req -> gnt=0 and valid=0 on the next edge.
- Rotation: req=8'hFF held, macro defined, MAX_HOLD=2 -> grant order 0,1,2,...,7,0, each held exactly 2 cycles, no idle gaps.
- Wrap priority: owner 7 releases with req=8'h81 -> next grant goes to 0, not 7. Then 0 releases with req=8'h80 -> grant goes to 7.
- No-timeout build: req=8'h08 held for 20 cycles, macro undefined -> gnt stays 8'h08 for all 20 cycles while other requests (req|=8'h01) wait.
- Data tracking: granted requester 3, toggle i[3] every cycle -> y follows i[3] with exactly one cycle lag; toggling other i bits has no effect on y.
